// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole allocator: round-robin arbitration over head-flit requests,
// packet-long lock on the winner, and credit-gated flit transfers to the crossbar.
`ifndef NPORT
`define NPORT 5
`endif

module wormhole_output_allocator #(
  parameter int size  = `NPORT,
  parameter int DEPTH = 4,
  localparam int SELW = (size > 1) ? $clog2(size) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [size-1:0] i_requests,
  input  logic [size-1:0] i_flit_valid,
  input  logic [size-1:0] i_tail,
  input  logic            i_credit,
  output logic [SELW-1:0] o_sel,
  output logic [size-1:0] o_grant,
  output logic            o_valid,
  output logic            o_busy,
  output logic [CW-1:0]   o_credits,
  output logic            o_credit_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t          r_state;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_last;
  logic [CW-1:0]   r_credits;
  logic            r_credit_err;

  logic [SELW-1:0] w_winner;
  logic            w_xfer;
  logic            w_tail;

  // Walk the candidates from farthest to nearest so the nearest requester after
  // r_last is written last and wins; r_last itself is the final candidate.
  always_comb begin
    w_winner = r_last;
    for (int i = size; i >= 1; i--) begin
      if (i_requests[SELW'((int'(r_last) + i) % size)]) begin
        w_winner = SELW'((int'(r_last) + i) % size);
      end
    end
  end

  assign w_xfer = (r_state == LOCKED) && i_flit_valid[r_sel] && (r_credits != '0);
  assign w_tail = i_tail[r_sel];

  always_comb begin
    o_grant = '0;
    if (w_xfer) begin
      o_grant[r_sel] = 1'b1;
    end
  end

  assign o_valid      = w_xfer;
  assign o_busy       = (r_state == LOCKED);
  assign o_sel        = r_sel;
  assign o_credits    = r_credits;
  assign o_credit_err = r_credit_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last       <= '0;
      r_credits    <= FULL;
      r_credit_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_requests) begin
            r_sel   <= w_winner;
            r_last  <= w_winner;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_xfer && w_tail) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A simultaneous transfer and credit return cancel out.
      if (w_xfer && !i_credit) begin
        r_credits <= r_credits - CW'(1);
      end else if (!w_xfer && i_credit) begin
        if (r_credits == FULL) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credits <= r_credits + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Bench for wormhole_output_allocator: directed scenarios followed by random
// traffic, all compared against a packet-level reference model.
module tb_wormhole_output_allocator;

  localparam int N   = 5;
  localparam int D   = 4;
  localparam int SW  = 3;
  localparam int CWT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  fv;
  logic [N-1:0]  tail;
  logic          credit;
  logic [SW-1:0] sel;
  logic [N-1:0]  grant;
  logic          valid;
  logic          busy;
  logic [CWT-1:0] credits;
  logic          cerr;

  int checks = 0;
  int errors = 0;

  int mOwner;
  int mLast;
  int mSel;
  int mCred;
  bit mErr;

  logic [N-1:0]   obsGrant;
  logic [SW-1:0]  obsSel;
  logic           obsBusy;
  logic [CWT-1:0] obsCredits;
  logic           obsErr;

  wormhole_output_allocator #(.size(N), .DEPTH(D)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_requests   (req),
    .i_flit_valid (fv),
    .i_tail       (tail),
    .i_credit     (credit),
    .o_sel        (sel),
    .o_grant      (grant),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_credits    (credits),
    .o_credit_err (cerr)
  );

  always #5 clk = ~clk;

  function automatic bit hasBit(input logic [N-1:0] v, input int idx);
    return (v & (N'(1) << idx)) != '0;
  endfunction

  function automatic bit mXfer(input logic [N-1:0] f);
    return (mOwner >= 0) && hasBit(f, mOwner) && (mCred > 0);
  endfunction

  function automatic int onehotIdx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (hasBit(g, i)) return i;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    mOwner = -1;
    mLast  = 0;
    mSel   = 0;
    mCred  = D;
    mErr   = 1'b0;
  endfunction

  // Packet-level view: who owns the output, who won last, and a credit balance.
  function automatic void modelStep(input logic [N-1:0] r, input logic [N-1:0] f,
                                    input logic [N-1:0] t, input logic c);
    bit x;
    x = mXfer(f);
    if (mOwner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (hasBit(r, (mLast + k) % N)) begin
          mOwner = (mLast + k) % N;
          mLast  = mOwner;
          mSel   = mOwner;
          break;
        end
      end
    end else if (x && hasBit(t, mOwner)) begin
      mOwner = -1;
    end
    mCred = mCred - int'(x) + int'(c);
    if (mCred > D) begin
      mCred = D;
      mErr  = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] f,
                               input logic [N-1:0] t, input logic c);
    logic [N-1:0] expGrant;
    @(negedge clk);
    req    = r;
    fv     = f;
    tail   = t;
    credit = c;
    #1;
    expGrant   = mXfer(f) ? (N'(1) << mOwner) : '0;
    obsGrant   = grant;
    obsSel     = sel;
    obsBusy    = busy;
    obsCredits = credits;
    obsErr     = cerr;
    checkOutput("grant",   32'(grant),   32'(expGrant));
    checkOutput("valid",   32'(valid),   32'(expGrant != '0));
    checkOutput("busy",    32'(busy),    32'(mOwner >= 0));
    checkOutput("sel",     32'(sel),     32'(mSel));
    checkOutput("credits", 32'(credits), 32'(mCred));
    checkOutput("cred_err", 32'(cerr),   32'(mErr));
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(r, f, t, c);
  endtask

  initial begin
    int order[$];
    int expOrder[6];
    int grants;
    logic [N-1:0] rr;
    logic [N-1:0] rf;
    logic [N-1:0] rt;

    expOrder = '{1, 2, 3, 4, 0, 1};
    rst_n = 1'b0; req = '0; fv = '0; tail = '0; credit = 1'b0;
    modelReset();
    applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("rst_credits", 32'(obsCredits), 32'(D));
    checkOutput("rst_busy", 32'(obsBusy), 32'd0);
    #2 rst_n = 1'b1;

    // All inputs request with single-flit packets; credits return as flits leave.
    for (int c = 0; c < 12; c++) begin
      applyStimulus('1, '1, '1, mXfer('1));
      if (obsGrant != '0) order.push_back(onehotIdx(obsGrant));
    end
    checkOutput("rr_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      checkOutput($sformatf("rr_order%0d", i), 32'(order[i]), 32'(expOrder[i]));
    end

    // Input 2 sends four flits while input 3 waits.
    applyStimulus(5'b01100, '0, '0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(5'b01000, 5'b00100, (k == 4) ? 5'b00100 : 5'b00000, 1'b1);
      checkOutput("pkt_grant", 32'(obsGrant), 32'b00100);
      checkOutput("pkt_busy", 32'(obsBusy), 32'd1);
    end
    applyStimulus(5'b01000, '0, '0, 1'b0);
    checkOutput("switch_bubble", 32'(obsBusy), 32'd0);
    applyStimulus('0, 5'b01000, 5'b01000, 1'b1);
    checkOutput("next_lock_sel", 32'(obsSel), 32'd3);
    checkOutput("next_lock_grant", 32'(obsGrant), 32'b01000);

    // Six-flit packet on input 0 with no credits returned.
    applyStimulus(5'b00001, '0, '0, 1'b0);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus('0, 5'b00001, '0, 1'b0);
      grants += int'(obsGrant[0]);
    end
    checkOutput("stall_grants", 32'(grants), 32'd4);
    checkOutput("stall_grant", 32'(obsGrant), 32'd0);
    checkOutput("stall_credits", 32'(obsCredits), 32'd0);
    checkOutput("stall_busy", 32'(obsBusy), 32'd1);
    grants = 0;
    applyStimulus('0, 5'b00001, '0, 1'b1);
    grants += int'(obsGrant[0]);
    applyStimulus('0, 5'b00001, '0, 1'b0);
    grants += int'(obsGrant[0]);
    applyStimulus('0, 5'b00001, '0, 1'b1);
    grants += int'(obsGrant[0]);
    applyStimulus('0, 5'b00001, 5'b00001, 1'b0);
    grants += int'(obsGrant[0]);
    checkOutput("resume_grants", 32'(grants), 32'd2);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("resume_idle", 32'(obsBusy), 32'd0);
    for (int c = 0; c < 4; c++) applyStimulus('0, '0, '0, 1'b1);

    // Transfer with simultaneous credit, then an overflowing credit return.
    applyStimulus(5'b00001, '0, '0, 1'b0);
    applyStimulus('0, 5'b00001, '0, 1'b0);
    applyStimulus('0, 5'b00001, '0, 1'b0);
    applyStimulus('0, 5'b00001, '0, 1'b1);
    checkOutput("pre_same_credits", 32'(obsCredits), 32'd2);
    applyStimulus('0, 5'b00001, 5'b00001, 1'b1);
    checkOutput("same_cycle_credits", 32'(obsCredits), 32'd2);
    applyStimulus('0, '0, '0, 1'b1);
    applyStimulus('0, '0, '0, 1'b1);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("full_no_err", 32'(obsErr), 32'd0);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("overflow_credits", 32'(obsCredits), 32'd4);
    checkOutput("overflow_err", 32'(obsErr), 32'd1);
    for (int c = 0; c < 3; c++) applyStimulus('0, '0, '0, 1'b0);
    checkOutput("err_sticky", 32'(obsErr), 32'd1);

    // Bubble of three cycles in the middle of a packet from input 0.
    applyStimulus(5'b00001, '0, '0, 1'b0);
    applyStimulus('0, 5'b00001, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, '0, '0, 1'b0);
      checkOutput("bubble_grant", 32'(obsGrant), 32'd0);
      checkOutput("bubble_busy", 32'(obsBusy), 32'd1);
    end
    applyStimulus('0, 5'b00001, '0, 1'b1);
    checkOutput("after_bubble_grant", 32'(obsGrant), 32'd1);
    applyStimulus('0, 5'b00001, 5'b00001, 1'b1);
    checkOutput("bubble_tail_grant", 32'(obsGrant), 32'd1);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("bubble_done", 32'(obsBusy), 32'd0);

    // Asynchronous reset while locked with one credit left.
    applyStimulus(5'b00001, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus('0, 5'b00001, '0, 1'b0);
    #3;
    checkOutput("pre_rst_credits", 32'(credits), 32'd1);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_grant", 32'(grant), 32'd0);
    checkOutput("async_valid", 32'(valid), 32'd0);
    checkOutput("async_credits", 32'(credits), 32'd4);
    checkOutput("async_sel", 32'(sel), 32'd0);
    checkOutput("async_err", 32'(cerr), 32'd0);
    applyStimulus('1, 5'b00001, '0, 1'b0);
    #2 rst_n = 1'b1;
    applyStimulus('1, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b0);
    checkOutput("post_rst_sel", 32'(obsSel), 32'd1);
    checkOutput("post_rst_busy", 32'(obsBusy), 32'd1);
    applyStimulus('0, 5'b00010, 5'b00010, 1'b1);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      rr = N'($urandom);
      rf = N'($urandom);
      rt = N'($urandom) & N'($urandom);
      applyStimulus(rr, rf, rt, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wormhole_output_allocator.md
# wormhole_output_allocator

- Per-output-port controller for the NoC router's crossbar.
- Arbitrates the input ports' head-flit requests for one output with the team's round-robin order and locks the winner for the whole packet, until its tail flit passes.
- Gates each flit transfer on downstream credits and drives the crossbar mux select and per-input pop strobes.
- One instance sits per router output, between the input buffers and the crossbar/link.

## Interface
Parameters:
- size, default `NPORT (5): number of input ports competing for this output.
- DEPTH, default 4: downstream buffer depth, which is also the initial credit count.

Ports (clock and reset first):
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_requests  input  size  per-input head-flit request for this output; the requester holds it until granted.
- i_flit_valid  input  size  per-input flit available at the buffer head.
- i_tail  input  size  per-input flag: the head flit is a tail (a single-flit packet is head and tail).
- i_credit  input  1  downstream freed one slot; one-cycle pulse.
- o_sel  output  $clog2(size)  crossbar mux select (registered).
- o_grant  output  size  one-hot pop strobe: the selected input's flit transfers this cycle.
- o_valid  output  1  flit forwarded downstream this cycle (equals |o_grant).
- o_busy  output  1  a packet currently owns the output.
- o_credits  output  $clog2(DEPTH+1)  current credit count (registered).
- o_credit_err  output  1  sticky; set on a credit return while the count is already DEPTH.

## Operation
State machine, two states:
- IDLE: o_busy=0, o_grant=0.
  - If |i_requests, run the round-robin search: start at lastport+1 and take the first set bit, wrapping from size-1 to 0. lastport itself is checked last.
  - Register the winner into o_sel and lastport, then go to LOCKED.
  - If no request, stay in IDLE; o_sel and lastport hold.
- LOCKED: o_busy=1; i_requests is ignored.
  - Transfer condition: xfer = i_flit_valid[o_sel] && (o_credits != 0).
  - On xfer: o_grant[o_sel]=1 and o_valid=1, combinationally in the same cycle.
  - On xfer with i_tail[o_sel]=1: return to IDLE next cycle.

Credit counter:
- Next value = o_credits - xfer + i_credit.
- Transfer and credit return in the same cycle: count unchanged.
- i_credit with o_credits==DEPTH and no xfer: count stays DEPTH, o_credit_err set. It clears only on reset.
- The counter operates in both states. Only xfer decrements it, and xfer occurs only in LOCKED.
- A credit returned in cycle N cannot enable a transfer in cycle N. Gating uses the registered count.

Invariants:
- o_grant is zero or one-hot.
- o_credits is never above DEPTH and never below 0.

## Timing
Reset (asynchronous assert, synchronous release on i_clk):
- state=IDLE, lastport=0, o_sel=0, o_credits=DEPTH, o_credit_err=0.
- o_busy=0, o_grant=0, o_valid=0.

Latency:
- Request first seen in IDLE at cycle N: o_sel and o_busy valid at N+1. The earliest flit transfer is at N+1.
- Streaming: with flits valid and credits available, one flit per cycle while LOCKED.
- Tail transfer at cycle T: IDLE at T+1, where arbitration runs again. The next lock is at T+2, so there is one bubble cycle per packet switch.
- A single-flit packet occupies the output for 2 cycles (arbitration cycle plus transfer cycle).

Boundary conditions:
- Credits exhausted mid-packet: stay in LOCKED with o_grant=0 until a credit arrives. The lock is never released without the tail.
- i_flit_valid[o_sel]=0 mid-packet (bubble): hold the lock, no transfer.
- Reset asserted mid-packet: the lock is dropped and credits reload to DEPTH. The upstream and downstream buffers are reset by the same i_rst_n.
- size=1: the search always selects 0.

## Test plan
- Reset, then i_requests=5'b11111 held with single-flit packets on every input -> grant order 1,2,3,4,0,1…; each o_sel update is 2 cycles apart.
- Input 2 sends a 4-flit packet (tail on the 4th) while input 3 also requests -> o_grant=5'b00100 for 4 consecutive cycles, o_busy=1 throughout, input 3 locks 2 cycles after the tail.
- DEPTH=4, 6-flit packet, no i_credit -> 4 transfers, then o_grant=0 and o_credits=0 with o_busy held. Two i_credit pulses then give exactly 2 more transfers, the last being the tail, and the block returns to IDLE.
- Transfer and i_credit in the same cycle with o_credits=2 -> o_credits stays 2. Then i_credit with no transfer at o_credits=4 -> stays 4 and o_credit_err=1, sticky.
- i_flit_valid on input 0 dropped for 3 cycles mid-packet -> no o_grant in those cycles, lock held, the packet completes afterwards.
- i_rst_n pulsed low asynchronously (between clock edges) while LOCKED with o_credits=1 -> outputs immediately take reset values, o_credits=4. With all ports requesting, the first grant after release goes to input 1.
